registre_decalage_n: RTL

//  WIDTH-bit universal register built from D-flop cells. Supports hold,

---
 rtl/registre_decalage_n_pkg.sv | 20 ++
 rtl/bascule_d_rn.sv | 31 +++
 rtl/registre_decalage_n.sv | 116 +++++++++++
 3 files changed

// File: rtl/registre_decalage_n_pkg.sv
// ---------------------------------------------------------------------------
// registre_pkg
//   Shared constants for the universal shift register and its serialiser.
//   - MODE_* : encodings of the 2-bit mode input.
//   - state_t: serialiser FSM states (IDLE -> SHIFT -> DONE -> IDLE).
// ---------------------------------------------------------------------------
package registre_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHL  = 2'b01;
    localparam logic [1:0] MODE_SHR  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/bascule_d_rn.sv
// ---------------------------------------------------------------------------
// bascule_d_rn
//   Single D flip-flop cell with asynchronous active-low reset.
//   Ports:
//     clk     in  rising-edge clock
//     rst_n   in  asynchronous reset, active-low
//     rst_val in  value taken by q while rst_n is low
//     d       in  data captured on each rising edge
//     q       out stored bit
//     q_n     out complement of q (derived from q, so never stale)
// ---------------------------------------------------------------------------
module bascule_d_rn (
    input  logic clk,
    input  logic rst_n,
    input  logic rst_val,
    input  logic d,
    output logic q,
    output logic q_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= rst_val;
        end else begin
            q <= d;
        end
    end

    assign q_n = ~q;

endmodule

// File: rtl/registre_decalage_n.sv
// ---------------------------------------------------------------------------
// registre_decalage_n
//   WIDTH-bit universal register (hold / shift left / shift right / load)
//   built from bascule_d_rn cells, plus an automatic LSB-first serialiser.
//   Ports:
//     clk       in  rising-edge clock
//     rst_n     in  asynchronous reset, active-low
//     mode      in  00 hold, 01 shift left, 10 shift right, 11 load
//     d         in  parallel load data
//     sin       in  serial fill bit for every shift
//     start     in  launch the serialiser (looked at in IDLE only)
//     q         out register contents
//     q_n       out bitwise complement of q
//     sout      out q[0], combinational
//     busy      out high during the WIDTH serialiser shift cycles
//     done      out one-cycle pulse after the last serialiser shift
//     state_dbg out current FSM state (debug observation only)
//
//   Handshake: start is a request sampled only while busy=0 and done=0
//   (IDLE); the edge that samples it loads d and raises busy. busy stays
//   high for exactly WIDTH cycles, during which sout presents d[0..WIDTH-1]
//   in order and start/mode are ignored. done then pulses for one cycle
//   (start/mode still ignored), after which a new start may be accepted.
// ---------------------------------------------------------------------------
module registre_decalage_n
    import registre_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             sout,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] q_next;

    // FSM and shift counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Next-state / next-contents logic. The register cells simply capture
    // q_next, so this block alone decides what the register does each edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        q_next     = q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    q_next     = d;
                    cnt_next   = CW'(WIDTH);
                    state_next = ST_SHIFT;
                end else begin
                    case (mode)
                        MODE_SHL:  q_next = {q[WIDTH-2:0], sin};
                        MODE_SHR:  q_next = {sin, q[WIDTH-1:1]};
                        MODE_LOAD: q_next = d;
                        default:   q_next = q;
                    endcase
                end
            end
            ST_SHIFT: begin
                // Right shift exposes the next data bit on q[0] (sout).
                q_next   = {sin, q[WIDTH-1:1]};
                cnt_next = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        bascule_d_rn u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .rst_val (RESET_VAL[i]),
            .d       (q_next[i]),
            .q       (q[i]),
            .q_n     (q_n[i])
        );
    end

    assign sout      = q[0];
    assign busy      = (state == ST_SHIFT);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

endmodule
